// File: rtl/cntr_wrap_mon.sv
// Wrap-event monitor for an up/down binary counter: detects wraps (and, with
// CNTR_WRAP_MON_DIRCHG_EN defined, direction changes) and queues them in a FIFO.
module cntr_wrap_mon #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             dir_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [1:0]       evt_type,
  output logic [WIDTH-1:0] evt_count,
  output logic [WRAPW-1:0] wrap_total,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] MAX_CNT  = '1;
  localparam logic [AW:0]      FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    EVT_NONE = 2'b00,
    EVT_UP   = 2'b01,
    EVT_DOWN = 2'b10,
    EVT_DIR  = 2'b11
  } evt_type_e;

  typedef struct packed {
    evt_type_e        kind;
    logic [WIDTH-1:0] cnt;
  } evt_rec_t;

  logic [WIDTH-1:0] prev_cnt;
  logic             primed;
  evt_type_e        det_type;
  logic             det;
  logic             is_wrap;

  evt_rec_t         mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             full;
  logic             push;
  logic             pop;
  evt_rec_t         head;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt <= '0;
      primed   <= 1'b0;
    end else begin
      prev_cnt <= cnt_in;
      primed   <= 1'b1;
    end
  end

`ifdef CNTR_WRAP_MON_DIRCHG_EN
  logic prev_dir;

  always_ff @(posedge clk) begin
    if (reset) prev_dir <= 1'b0;
    else       prev_dir <= dir_in;
  end
`endif

  // NOTE: det_type gets a default before any branch so no latch is inferred.
  always_comb begin
    det_type = EVT_NONE;
    if (primed) begin
      if (prev_cnt == MAX_CNT && cnt_in == '0 && !dir_in)
        det_type = EVT_UP;
      else if (prev_cnt == '0 && cnt_in == MAX_CNT && dir_in)
        det_type = EVT_DOWN;
`ifdef CNTR_WRAP_MON_DIRCHG_EN
      else if (dir_in != prev_dir)
        det_type = EVT_DIR;
`endif
    end
  end

  assign det     = (det_type != EVT_NONE);
  assign is_wrap = (det_type == EVT_UP) || (det_type == EVT_DOWN);

  assign full      = (occ == FULL_OCC);
  assign evt_valid = (occ != '0);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = det && (!full || pop);

  // NOTE: the storage array is not reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{kind: det_type, cnt: cnt_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
      wrap_total <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (det && !push) overflow <= 1'b1;
      if (is_wrap && wrap_total != '1) wrap_total <= wrap_total + 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_type  = evt_valid ? head.kind : EVT_NONE;
  assign evt_count = evt_valid ? head.cnt  : '0;

endmodule

// File: tb/tb_cntr_wrap_mon.sv
// Self-checking bench for cntr_wrap_mon: vector table, corner-case sequences,
// and randomized stimulus against a queue-based reference model.
module tb_cntr_wrap_mon;

  localparam int WIDTH = 3;
  localparam int DEPTH = 4;
  localparam int WRAPW = 8;
`ifdef CNTR_WRAP_MON_DIRCHG_EN
  localparam bit DIRCHG = 1'b1;
`else
  localparam bit DIRCHG = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] cnt_in;
  logic             dir_in;
  logic             evt_ready;
  logic             evt_valid;
  logic [1:0]       evt_type;
  logic [WIDTH-1:0] evt_count;
  logic [WRAPW-1:0] wrap_total;
  logic             overflow;

  cntr_wrap_mon #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAPW(WRAPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .dir_in     (dir_in),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_type   (evt_type),
    .evt_count  (evt_count),
    .wrap_total (wrap_total),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: events as a plain queue of {type, count} records.
  typedef struct packed {
    logic [1:0]       t;
    logic [WIDTH-1:0] c;
  } evt_t;

  evt_t             mq[$];
  int               m_total;
  bit               m_ovf;
  bit               m_primed;
  int               m_prev_cnt;
  bit               m_prev_dir;

  task automatic model_step(input bit r, input int c, input bit d, input bit y);
    bit   has_evt;
    evt_t e;
    if (r) begin
      mq.delete();
      m_total = 0; m_ovf = 0; m_primed = 0; m_prev_cnt = 0; m_prev_dir = 0;
      return;
    end
    has_evt = 0;
    e = '0;
    if (m_primed) begin
      if (m_prev_cnt == 7 && c == 0 && !d) begin
        has_evt = 1; e.t = 2'b01; e.c = WIDTH'(c);
      end else if (m_prev_cnt == 0 && c == 7 && d) begin
        has_evt = 1; e.t = 2'b10; e.c = WIDTH'(c);
      end else if (DIRCHG && d != m_prev_dir) begin
        has_evt = 1; e.t = 2'b11; e.c = WIDTH'(c);
      end
    end
    if (has_evt && e.t != 2'b11 && m_total < 255) m_total++;
    if (mq.size() > 0 && y) void'(mq.pop_front());
    if (has_evt) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
    end
    m_prev_cnt = c;
    m_prev_dir = d;
    m_primed   = 1;
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({evt_valid, evt_type, evt_count, wrap_total, overflow});
  endfunction

  function automatic logic [31:0] model_vec();
    evt_t h;
    bit   v;
    v = (mq.size() != 0);
    h = v ? mq[0] : '0;
    return 32'({v, h.t, h.c, 8'(m_total), m_ovf});
  endfunction

  // Apply one cycle of inputs, advance past the edge, compare against the model.
  task automatic step(input bit r, input int c, input bit d, input bit y);
    reset     = r;
    cnt_in    = WIDTH'(c);
    dir_in    = d;
    evt_ready = y;
    model_step(r, c, d, y);
    @(posedge clk);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    bit         rst;
    int         cnt;
    bit         dir;
    bit         rdy;
    bit         v;
    logic [1:0] t;
    logic [2:0] c;
    logic [7:0] tot;
    bit         ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, int cnt, bit dir, bit rdy,
                              bit v, logic [1:0] t, logic [2:0] c, logic [7:0] tot, bit ov);
    vec_t e;
    e.rst = rst; e.cnt = cnt; e.dir = dir; e.rdy = rdy;
    e.v = v; e.t = t; e.c = c; e.tot = tot; e.ov = ov;
    vecs.push_back(e);
  endfunction

  initial begin
    reset = 1'b1; cnt_in = '0; dir_in = 1'b0; evt_ready = 1'b0;

    // Up count 0..7,0: single up-wrap, visible the cycle after the 7->0 sample.
    add(1, 7, 0, 1, 0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    for (int c = 1; c <= 7; c++) add(0, c, 0, 1, 0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 1, 1, 2'b01, 0, 1, 0);
    add(0, 1, 0, 1, 0, 2'b00, 0, 1, 0);
    // Down count 2,1,0,7,6.
    add(1, 2, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 2, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 0, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 7, 1, 1, 1, 2'b10, 7, 1, 0);
    add(0, 6, 1, 1, 0, 2'b00, 0, 1, 0);
    // Priming: 7 before reset, 0 right after reset gives no event; later 0->7 down is a wrap.
    add(0, 7, 1, 1, 0, 2'b00, 0, 1, 0);
    add(1, 7, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    add(0, 7, 1, 1, 1, 2'b10, 7, 1, 0);
    add(0, 6, 1, 1, 0, 2'b00, 0, 1, 0);
    // Priming also blocks a would-be down-wrap against the reset prev_cnt of 0.
    add(1, 0, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 7, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 6, 1, 1, 0, 2'b00, 0, 0, 0);
    // Direction change 0->1 at count 3.
    add(1, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    add(0, 1, 0, 1, 0, 2'b00, 0, 0, 0);
    add(0, 2, 0, 1, 0, 2'b00, 0, 0, 0);
    add(0, 3, 1, 1, DIRCHG, DIRCHG ? 2'b11 : 2'b00, DIRCHG ? 3'd3 : 3'd0, 0, 0);
    add(0, 2, 1, 1, 0, 2'b00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].cnt, vecs[i].dir, vecs[i].rdy);
      check($sformatf("vec%0d", i), dut_vec(),
            32'({vecs[i].v, vecs[i].t, vecs[i].c, vecs[i].tot, vecs[i].ov}));
    end

    // Backpressure: five alternating down/up wraps with evt_ready low.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step(0, 7, 1, 0);
      else            step(0, 0, 0, 0);
    end
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_total", 32'(wrap_total), 32'd5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_head%0d", k), 32'({evt_valid, evt_type, evt_count}),
            (k % 2 == 0) ? 32'({1'b1, 2'b10, 3'd7}) : 32'({1'b1, 2'b01, 3'd0}));
      step(0, 7, 1, 1);
    end
    check("bp_drained", 32'(evt_valid), 32'd0);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop in the same cycle as a new wrap.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step(0, 7, 1, 0);
      else            step(0, 0, 0, 0);
    end
    step(0, 7, 1, 1);
    check("full_pop_ovf", 32'(overflow), 32'd0);
    check("full_pop_total", 32'(wrap_total), 32'd5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full_head%0d", k), 32'({evt_valid, evt_type, evt_count}),
            (k % 2 == 0) ? 32'({1'b1, 2'b01, 3'd0}) : 32'({1'b1, 2'b10, 3'd7}));
      step(0, 7, 1, 1);
    end
    check("full_drained", 32'(evt_valid), 32'd0);

    // Reset with three events queued.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 7, 1, 0);
    step(0, 0, 0, 0);
    step(0, 7, 1, 0);
    check("rst_pre_valid", 32'(evt_valid), 32'd1);
    check("rst_pre_total", 32'(wrap_total), 32'd3);
    step(1, 0, 0, 0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_total", 32'(wrap_total), 32'd0);

    // Saturation: 260 back-to-back wraps drained every cycle.
    step(0, 0, 0, 1);
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) step(0, 7, 1, 1);
      else            step(0, 0, 0, 1);
    end
    check("sat_total", 32'(wrap_total), 32'd255);
    check("sat_no_ovf", 32'(overflow), 32'd0);

    // Randomized walk with occasional jumps, reversals, resets and ready phases.
    begin
      int c;
      bit d;
      bit r;
      bit y;
      c = 0;
      d = 0;
      step(1, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
        r = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 9) == 0) d = ~d;
        if ($urandom_range(0, 19) == 0) c = $urandom_range(0, 7);
        else c = d ? (c + 7) % 8 : (c + 1) % 8;
        if ((i / 60) % 2 == 1) y = ($urandom_range(0, 3) != 0);
        else                   y = ($urandom_range(0, 3) == 0);
        step(r, c, d, y);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
